// File: rtl/rst_pkg.sv
// Shared definitions for the reset release sequencer and its helpers.
package rst_pkg;

    // Sequencer FSM states.
    typedef enum logic [1:0] {
        HOLD     = 2'd0,
        GAP      = 2'd1,
        WAIT_ACK = 2'd2,
        RUN      = 2'd3
    } seq_state_t;

    // Counter width able to hold max(a, b) - 1, never narrower than one bit.
    function automatic int cnt_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/rst_sync.sv
// Reset synchroniser: asserts asynchronously, deasserts after SYNC_STAGES clk edges.
module rst_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic srst_n
);

    logic [SYNC_STAGES-1:0] sync;

    // Shift ones into the chain once rst_n is released; clear it at once on assertion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign srst_n = sync[SYNC_STAGES-1];

endmodule

// File: rtl/rst_release_seq.sv
// Releases NUM_STAGES downstream reset domains in order, each gated by the
// previous domain's ack (or a timeout), with a soft re-sequence path.
module rst_release_seq
    import rst_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int STAGE_DELAY = 16,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  soft_rst_req,
    input  logic [NUM_STAGES-1:0] stage_ack,
    output logic [NUM_STAGES-1:0] stage_rst_n,
    output logic                  sys_ready,
    output logic [2:0]            cur_stage,
    output logic [NUM_STAGES-1:0] timeout_err
);

    localparam int              CW           = cnt_width(STAGE_DELAY, ACK_TIMEOUT);
    localparam logic [CW-1:0]   DELAY_LAST   = CW'(STAGE_DELAY - 1);
    localparam logic [CW-1:0]   TIMEOUT_LAST = CW'(ACK_TIMEOUT - 1);
    localparam logic [2:0]      LAST_STAGE   = 3'(NUM_STAGES - 1);

    seq_state_t    state;
    logic [CW-1:0] cnt;
    logic          srst_n;
    logic          ack_hit;
    logic          timed_out;

    // One-hot select of stage idx; avoids indexing a short vector with a 3-bit index.
    function automatic logic [NUM_STAGES-1:0] onehot(input logic [2:0] idx);
        logic [NUM_STAGES-1:0] v;
        v = '0;
        for (int j = 0; j < NUM_STAGES; j++) begin
            if (3'(j) == idx) v[j] = 1'b1;
        end
        return v;
    endfunction

    // Thermometer mask with stages 0..idx released; keeps release order by construction.
    function automatic logic [NUM_STAGES-1:0] thermo(input logic [2:0] idx);
        logic [NUM_STAGES-1:0] v;
        v = '0;
        for (int j = 0; j < NUM_STAGES; j++) begin
            v[j] = (3'(j) <= idx);
        end
        return v;
    endfunction

    rst_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_rst_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .srst_n(srst_n)
    );

    assign ack_hit   = |(stage_ack & onehot(cur_stage));
    assign timed_out = (cnt == TIMEOUT_LAST);

    // Sequencer FSM: cur_stage doubles as the index k of the stage being released/awaited.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HOLD;
            cnt         <= '0;
            cur_stage   <= '0;
            stage_rst_n <= '0;
            sys_ready   <= 1'b0;
            timeout_err <= '0;
        end else if (soft_rst_req) begin
            // Timeout history survives a soft re-sequence on purpose.
            state       <= HOLD;
            cnt         <= '0;
            cur_stage   <= '0;
            stage_rst_n <= '0;
            sys_ready   <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (srst_n) begin
                        if (cnt == DELAY_LAST) begin
                            stage_rst_n <= thermo(3'd0);
                            cur_stage   <= '0;
                            cnt         <= '0;
                            state       <= WAIT_ACK;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (cnt == DELAY_LAST) begin
                        stage_rst_n <= thermo(cur_stage);
                        cnt         <= '0;
                        state       <= WAIT_ACK;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_ACK: begin
                    if (ack_hit || timed_out) begin
                        if (!ack_hit) begin
                            timeout_err <= timeout_err | onehot(cur_stage);
                        end
                        cnt <= '0;
                        if (cur_stage == LAST_STAGE) begin
                            sys_ready <= 1'b1;
                            state     <= RUN;
                        end else begin
                            cur_stage <= cur_stage + 3'd1;
                            state     <= GAP;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    // Ack drops are ignored here; only a soft or hard reset re-sequences.
                end
                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end

endmodule

// File: doc/rst_release_seq.md
Name: rst_release_seq

Overview:
- Consumer-side counterpart to the board reset generator.
- Takes the clean async reset, synchronises its deassertion into clk, and releases NUM_STAGES downstream reset domains in strict order.
- Before releasing the next domain, it waits for a ready/ack from the previous one, or for a timeout.
- Provides a soft-reset re-sequence path and a system-ready flag.

Parameters:
- NUM_STAGES, 4, number of sequenced reset outputs (1..8).
- SYNC_STAGES, 2, flops in the reset deassertion synchroniser (>=2).
- STAGE_DELAY, 16, clk cycles between release trigger and the stage's reset deassertion (>=1).
- ACK_TIMEOUT, 1024, max clk cycles to wait for stage_ack before forcing progress (>=2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset; async assert, deassert synchronised internally.
- soft_rst_req  in  1  synchronous pulse; requests full re-sequence.
- stage_ack  in  NUM_STAGES  per-domain "out of reset and ready", level; asynchronous to sequencing, but assumed synchronous to clk.
- stage_rst_n  out  NUM_STAGES  per-domain active-low reset, registered.
- sys_ready  out  1  high when all stages released and acknowledged.
- cur_stage  out  3  index of stage being released/awaited; 0 in HOLD, NUM_STAGES-1 in RUN.
- timeout_err  out  NUM_STAGES  sticky per-stage timeout flags.

Behaviour:
- Internal reset:
  - rst_n low asynchronously clears everything: stage_rst_n=0, sys_ready=0, cur_stage=0, timeout_err=0, state=HOLD, counter=0.
  - srst_n = rst_n through SYNC_STAGES flops; asserts async, deasserts on the SYNC_STAGES-th clk edge after rst_n rises.
- FSM states: HOLD, GAP, WAIT_ACK, RUN.
- HOLD:
  - Counter increments from 0 while srst_n=1.
  - When counter==STAGE_DELAY-1, stage_rst_n[0] goes high at that edge and the FSM goes to WAIT_ACK with k=0 and counter cleared.
  - Net: stage_rst_n[0] rises at edge SYNC_STAGES+STAGE_DELAY after rst_n rises.
- WAIT_ACK(k):
  - Counter increments each cycle.
  - If stage_ack[k] is sampled high, or counter==ACK_TIMEOUT-1 with ack low, the wait ends.
  - On timeout, timeout_err[k] is set at that edge.
  - If k==NUM_STAGES-1: go to RUN and set sys_ready=1 at that edge.
  - Otherwise: go to GAP, increment k, clear counter.
  - An ack already high on the release edge is sampled the next edge (minimum 1-cycle WAIT_ACK).
- GAP(k):
  - Counter increments; at counter==STAGE_DELAY-1, stage_rst_n[k] goes high and the FSM goes to WAIT_ACK(k).
  - Net: release of stage k+1 happens STAGE_DELAY edges after the ack/timeout edge of stage k.
- RUN:
  - Holds all outputs.
  - Deassertion of any stage_ack is ignored; there is no auto re-sequence.
- soft_rst_req (any state, sampled high):
  - Next edge: all stage_rst_n=0, sys_ready=0, k=0, counter=0, state=HOLD.
  - timeout_err is not cleared; only rst_n clears it.
  - Re-sequence then proceeds exactly as from HOLD (no synchroniser delay).
  - A request in HOLD restarts the counter.
- Ordering invariant: stage_rst_n is thermometer-coded at all times (bit j high implies all bits below j high); the bench asserts this every cycle.
- Mid-sequence rst_n assertion: all outputs low asynchronously, regardless of state.
- Counter width: clog2 of max(STAGE_DELAY, ACK_TIMEOUT) bits; must not wrap before the terminal compare.
- cur_stage width: fixed 3 bits; the unused MSBs are 0.

Decomposition:
- Shared package rst_pkg: FSM state enum (HOLD, GAP, WAIT_ACK, RUN) and a width helper function for counter sizing.
- One sub-module: rst_sync (SYNC_STAGES flop chain; async assert, sync deassert; output srst_n). It is reused elsewhere for per-clock-domain resets.

Test Plan (defaults NUM_STAGES=4, STAGE_DELAY=16, ACK_TIMEOUT=1024):
- Power-up, acks tied high:
  - Stimulus: rst_n rises at edge 0.
  - Required: stage_rst_n=4'b0001 at edge 18, 4'b0011 at 35, 4'b0111 at 52, 4'b1111 at 69; sys_ready=1 at 70; timeout_err=0.
- Ack stall:
  - Stimulus: stage_ack[1] held low.
  - Required: timeout_err[1] sets exactly 1024 edges after stage 1 release; sequence continues; final timeout_err=4'b0010; sys_ready=1.
- Soft reset in RUN:
  - Stimulus: 1-cycle soft_rst_req.
  - Required: next edge stage_rst_n=0 and sys_ready=0; stage_rst_n[0] re-rises 16 edges later; timeout_err is preserved.
- Async reset mid-sequence:
  - Stimulus: rst_n low while in WAIT_ACK(2).
  - Required: outputs clear with no clk edge; release resumes per power-up timing.
- Ack glitch in RUN:
  - Stimulus: stage_ack[0] drops for 5 cycles.
  - Required: no output change.
- Back-to-back soft_rst_req during GAP:
  - Stimulus: 3 requests, 4 cycles apart.
  - Required: thermometer invariant holds; stage_rst_n[0] rises 16 edges after the last request.
